// File: rtl/fetch_sequencer.sv
// Fetch-stage control: arbitrates halt / jump / load-use hazard, sequences
// the PC redirect and decode flush, and keeps saturating perf counters.
// Control outputs are flops loaded from the next-state decode, so an input
// sampled on edge N is visible on the outputs right after edge N.
module fetch_sequencer #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC    = '0,
    parameter int                FLUSH_CYCLES = 2,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              resume,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              hazard,
    input  logic              clr_cnt,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic              flush,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  redirect_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [2:0] {
        BOOT     = 3'd0,
        RUN      = 3'd1,
        REDIRECT = 3'd2,
        FLUSH    = 3'd3,
        HOLD     = 3'd4,
        HALT     = 3'd5
    } state_e;

    // FLUSH is held for FLUSH_CYCLES-1 cycles; counter runs down to zero.
    localparam logic [3:0] FLUSH_LOAD = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_e              state_q, state_d;
    logic [3:0]          fcnt_q, fcnt_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic                booted_q;
    logic                pc_mux_d, stall_d, stall_pm_d, flush_d;
    logic [ADDR_W-1:0]   jmp_loc_d;

    assign state = state_q;

    // Next-state arbitration (halt > jmp_req > hazard) and next output decode.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        target_d   = target_q;
        pc_mux_d   = 1'b0;
        stall_d    = 1'b0;
        stall_pm_d = 1'b0;
        flush_d    = 1'b0;
        jmp_loc_d  = jmp_loc;

        case (state_q)
            // The reset cycle itself shows reset outputs; one real BOOT
            // cycle follows it so RESET_VEC is always presented to the PC.
            BOOT:     state_d = booted_q ? RUN : BOOT;
            RUN, HOLD: begin
                if (halt)         state_d = HALT;
                else if (jmp_req) state_d = REDIRECT;
                else if (hazard)  state_d = HOLD;
                else              state_d = RUN;
            end
            // hazard is not looked at here: the flushed slot resolves it.
            REDIRECT: begin
                if (halt)                   state_d = HALT;
                else if (jmp_req)           state_d = REDIRECT;
                else if (FLUSH_CYCLES == 1) state_d = RUN;
                else begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (halt)              state_d = HALT;
                else if (jmp_req)      state_d = REDIRECT;
                else if (fcnt_q == '0) state_d = RUN;
                else                   fcnt_d  = fcnt_q - 4'd1;
            end
            HALT: begin
                if (resume && !halt) state_d = jmp_req ? REDIRECT : RUN;
            end
            default:  state_d = BOOT;
        endcase

        if (state_d == REDIRECT) target_d = jmp_target;

        case (state_d)
            BOOT: begin
                pc_mux_d   = 1'b1;
                jmp_loc_d  = RESET_VEC;
                stall_pm_d = 1'b1;
            end
            REDIRECT: begin
                pc_mux_d   = 1'b1;
                jmp_loc_d  = target_d;
                stall_pm_d = 1'b1;
                flush_d    = 1'b1;
            end
            FLUSH: begin
                stall_pm_d = 1'b1;
                flush_d    = 1'b1;
            end
            HOLD, HALT: begin
                stall_d    = 1'b1;
                stall_pm_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, target, flush counter and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            fcnt_q     <= '0;
            target_q   <= '0;
            booted_q   <= 1'b0;
            pc_mux_sel <= 1'b0;
            jmp_loc    <= '0;
            stall      <= 1'b1;
            stall_pm   <= 1'b1;
            flush      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            target_q   <= target_d;
            booted_q   <= 1'b1;
            pc_mux_sel <= pc_mux_d;
            jmp_loc    <= jmp_loc_d;
            stall      <= stall_d;
            stall_pm   <= stall_pm_d;
            flush      <= flush_d;
        end
    end

    // Saturating perf counters; clear wins over increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else if (clr_cnt) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (state_d == REDIRECT && redirect_cnt != '1)
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            if ((state_q == HOLD || state_q == HALT) && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
